// File: rtl/clic_target_if.sv
// Core-side interrupt offer channel: valid/ready to hand over an interrupt,
// kill_req/kill_ack to withdraw an offer that has gone stale or been preempted.
interface clic_target_if #(
    parameter int unsigned SrcWidth  = 8,
    parameter int unsigned PrioWidth = 8,
    parameter int unsigned ModeWidth = 2
);
    // An offer is taken on any cycle where irq_valid & irq_ready; a withdrawal on irq_kill_req & irq_kill_ack.
    logic                 irq_valid;
    logic                 irq_ready;
    logic [SrcWidth-1:0]  irq_id;
    logic [PrioWidth-1:0] irq_max;
    logic [ModeWidth-1:0] irq_mode;
    logic                 irq_kill_req;
    logic                 irq_kill_ack;

    modport master (
        output irq_valid, irq_id, irq_max, irq_mode, irq_kill_req,
        input  irq_ready, irq_kill_ack
    );

    modport slave (
        input  irq_valid, irq_id, irq_max, irq_mode, irq_kill_req,
        output irq_ready, irq_kill_ack
    );
endinterface

// File: rtl/clic_target_pipelined.sv
// CLIC target arbiter: pipelined (mode, level) max-tree over all sources feeding a
// one-hart offer/claim/kill handshake with a post-claim flush of stale tree contents.
module clic_target_pipelined #(
    parameter int unsigned N_SOURCE   = 256,
    parameter int unsigned PrioWidth  = 8,
    parameter int unsigned ModeWidth  = 2,
    parameter int unsigned PipeStages = 0,
    localparam int unsigned SrcWidth  = $clog2(N_SOURCE)
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [N_SOURCE-1:0]                 ip_i,
    input  logic [N_SOURCE-1:0]                 ie_i,
    input  logic [N_SOURCE-1:0]                 le_i,
    input  logic [N_SOURCE-1:0][PrioWidth-1:0]  prio_i,
    input  logic [N_SOURCE-1:0][ModeWidth-1:0]  mode_i,
    input  logic [PrioWidth-1:0]                thresh_i,
    output logic [N_SOURCE-1:0]                 claim_o,
    clic_target_if.master                       irq,
    output logic [1:0]                          dbg_state_o
);

    localparam int unsigned Levels  = SrcWidth;
    localparam int unsigned NumLeaf = 1 << Levels;
    localparam int Step = (PipeStages == 0) ? 1 : int'((Levels + PipeStages - 1) / PipeStages);
    localparam int unsigned CntW = (PipeStages > 0) ? $clog2(PipeStages + 1) : 1;
    localparam logic [CntW-1:0] FlushLast = CntW'((PipeStages > 0) ? PipeStages - 1 : 0);

    typedef struct packed {
        logic                 is;
        logic [SrcWidth-1:0]  id;
        logic [PrioWidth-1:0] max;
        logic [ModeWidth-1:0] mode;
    } node_t;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAck   = 2'd1,
        StClaim = 2'd2,
        StFlush = 2'd3
    } state_e;

    // Register slots sit at depths 0, Step, 2*Step, ... from the root; slots that would fall
    // below the leaves stack up on the leaf level so the total latency is always PipeStages.
    function automatic int regs_at_depth(input int d);
        int cnt;
        int pos;
        cnt = 0;
        for (int k = 0; k < int'(PipeStages); k++) begin
            pos = k * Step;
            if (pos > int'(Levels)) pos = int'(Levels);
            if (pos == d) cnt++;
        end
        return cnt;
    endfunction

    node_t node_raw [1:2*NumLeaf-1];
    node_t node_out [1:2*NumLeaf-1];

    for (genvar i = 0; i < NumLeaf; i++) begin : g_leaf
        if (i < N_SOURCE) begin : g_real
            assign node_raw[NumLeaf+i] = '{is: ip_i[i] & ie_i[i], id: SrcWidth'(i),
                                           max: prio_i[i], mode: mode_i[i]};
        end else begin : g_pad
            assign node_raw[NumLeaf+i] = '{is: 1'b0, id: SrcWidth'(i), max: '0, mode: '0};
        end
    end

    // Full ties keep the left child so the lower id wins.
    for (genvar n = 1; n < NumLeaf; n++) begin : g_node
        node_t c0;
        node_t c1;
        logic  c1_wins;
        assign c0 = node_out[2*n];
        assign c1 = node_out[2*n+1];
        assign c1_wins = c1.is & (~c0.is | (c1.mode > c0.mode) |
                                  ((c1.mode == c0.mode) & (c1.max > c0.max)));
        assign node_raw[n] = c1_wins ? c1 : c0;
    end

    for (genvar n = 1; n < 2*NumLeaf; n++) begin : g_pipe
        localparam int NRegs = regs_at_depth($clog2(n + 1) - 1);
        if (NRegs == 0) begin : g_wire
            assign node_out[n] = node_raw[n];
        end else begin : g_reg
            node_t stage_q [NRegs];
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    for (int s = 0; s < NRegs; s++) stage_q[s] <= '0;
                end else begin
                    stage_q[0] <= node_raw[n];
                    for (int s = 1; s < NRegs; s++) stage_q[s] <= stage_q[s-1];
                end
            end
            assign node_out[n] = stage_q[NRegs-1];
        end
    end

    node_t root;
    logic  root_valid;
    assign root       = node_out[1];
    assign root_valid = root.is & (root.max > thresh_i);

    // Power-of-two views so the offered id can index them without range concerns.
    logic [NumLeaf-1:0] ip_pad;
    logic [NumLeaf-1:0] ie_pad;
    logic [NumLeaf-1:0] le_pad;
    assign ip_pad = NumLeaf'(ip_i);
    assign ie_pad = NumLeaf'(ie_i);
    assign le_pad = NumLeaf'(le_i);

    state_e               state_q;
    logic                 valid_q;
    logic                 kill_q;
    logic [NumLeaf-1:0]   claim_q;
    logic [SrcWidth-1:0]  id_q;
    logic [PrioWidth-1:0] max_q;
    logic [ModeWidth-1:0] mode_q;
    logic [CntW-1:0]      cnt_q;

    logic level_gone;
    logic preempt;
    logic below_thresh;
    assign level_gone   = ~le_pad[id_q] & (~ip_pad[id_q] | ~ie_pad[id_q]);
    assign preempt      = root_valid & (root.id != id_q) &
                          ((root.mode > mode_q) | ((root.mode == mode_q) & (root.max > max_q)));
    assign below_thresh = (max_q <= thresh_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
            kill_q  <= 1'b0;
            claim_q <= '0;
            id_q    <= '0;
            max_q   <= '0;
            mode_q  <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (root_valid) begin
                        id_q    <= root.id;
                        max_q   <= root.max;
                        mode_q  <= root.mode;
                        valid_q <= 1'b1;
                        state_q <= StAck;
                    end
                end
                StAck: begin
                    if (level_gone) begin
                        valid_q <= 1'b0;
                        kill_q  <= 1'b0;
                        state_q <= StIdle;
                    end else if (valid_q & irq.irq_ready) begin
                        valid_q       <= 1'b0;
                        kill_q        <= 1'b0;
                        claim_q       <= '0;
                        claim_q[id_q] <= 1'b1;
                        state_q       <= StClaim;
                    end else if (kill_q & irq.irq_kill_ack) begin
                        valid_q <= 1'b0;
                        kill_q  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        // Re-evaluated every cycle so the request withdraws if the reason goes away.
                        kill_q <= preempt | below_thresh;
                    end
                end
                StClaim: begin
                    claim_q <= '0;
                    cnt_q   <= '0;
                    state_q <= (PipeStages > 0) ? StFlush : StIdle;
                end
                StFlush: begin
                    if (cnt_q == FlushLast) begin
                        cnt_q   <= '0;
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign claim_o          = claim_q[N_SOURCE-1:0];
    assign irq.irq_valid    = valid_q;
    assign irq.irq_id       = id_q;
    assign irq.irq_max      = max_q;
    assign irq.irq_mode     = mode_q;
    assign irq.irq_kill_req = kill_q;
    assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_clic_target_pipelined.sv
// Directed bench: one combinational-tree instance and one two-stage pipelined instance
// driven through hand-timed handshake sequences with hand-computed expectations.
module tb_clic_target_pipelined;

    localparam int N = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]       ip0, ie0, le0, claim0;
    logic [N-1:0][7:0]  prio0;
    logic [N-1:0][1:0]  mode0;
    logic [7:0]         th0;
    logic [1:0]         st0;

    logic [N-1:0]       ip2, ie2, le2, claim2;
    logic [N-1:0][7:0]  prio2;
    logic [N-1:0][1:0]  mode2;
    logic [7:0]         th2;
    logic [1:0]         st2;

    int n_cmp = 0;
    int n_mis = 0;

    clic_target_if #(.SrcWidth(4), .PrioWidth(8), .ModeWidth(2)) bus0 ();
    clic_target_if #(.SrcWidth(4), .PrioWidth(8), .ModeWidth(2)) bus2 ();

    clic_target_pipelined #(.N_SOURCE(N), .PrioWidth(8), .ModeWidth(2), .PipeStages(0)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .ip_i(ip0), .ie_i(ie0), .le_i(le0), .prio_i(prio0),
        .mode_i(mode0), .thresh_i(th0), .claim_o(claim0), .irq(bus0), .dbg_state_o(st0)
    );

    clic_target_pipelined #(.N_SOURCE(N), .PrioWidth(8), .ModeWidth(2), .PipeStages(2)) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n), .ip_i(ip2), .ie_i(ie2), .le_i(le2), .prio_i(prio2),
        .mode_i(mode2), .thresh_i(th2), .claim_o(claim2), .irq(bus2), .dbg_state_o(st2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        ip0 = '0; ie0 = '0; le0 = '1; prio0 = '0; mode0 = '0; th0 = 8'd0;
        ip2 = '0; ie2 = '0; le2 = '1; prio2 = '0; mode2 = '0; th2 = 8'd0;
        bus0.irq_ready = 1'b0; bus0.irq_kill_ack = 1'b0;
        bus2.irq_ready = 1'b0; bus2.irq_kill_ack = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid0", 32'(bus0.irq_valid), 32'd0);
        chk("rst_kill0", 32'(bus0.irq_kill_req), 32'd0);
        chk("rst_claim0", 32'(claim0), 32'd0);
        chk("rst_state0", 32'(st0), 32'd0);
        chk("rst_id0", 32'(bus0.irq_id), 32'd0);
        chk("rst_valid2", 32'(bus2.irq_valid), 32'd0);
        rst_n = 1'b1;
        step();
        chk("idle_after_reset", 32'(st0), 32'd0);

        // T1: basic offer and claim
        prio0[5] = 8'd3; mode0[5] = 2'd3; ip0[5] = 1'b1; ie0[5] = 1'b1;
        step();
        chk("t1_valid_c1", 32'(bus0.irq_valid), 32'd1);
        chk("t1_id", 32'(bus0.irq_id), 32'd5);
        chk("t1_max", 32'(bus0.irq_max), 32'd3);
        chk("t1_mode", 32'(bus0.irq_mode), 32'd3);
        step();
        chk("t1_valid_c2", 32'(bus0.irq_valid), 32'd1);
        bus0.irq_ready = 1'b1;
        step();
        chk("t1_claim", 32'(claim0), 32'h0020);
        chk("t1_valid_claim", 32'(bus0.irq_valid), 32'd0);
        chk("t1_state_claim", 32'(st0), 32'd2);
        bus0.irq_ready = 1'b0; ip0[5] = 1'b0;
        step();
        chk("t1_claim_gone", 32'(claim0), 32'd0);
        chk("t1_state_idle", 32'(st0), 32'd0);

        // T2: threshold filter, then threshold-driven kill that withdraws
        prio0[7] = 8'd2; mode0[7] = 2'd0; ip0[7] = 1'b1; ie0[7] = 1'b1; th0 = 8'd2;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t2_blocked", 32'(bus0.irq_valid), 32'd0);
        end
        th0 = 8'd1;
        step();
        chk("t2_valid", 32'(bus0.irq_valid), 32'd1);
        chk("t2_id", 32'(bus0.irq_id), 32'd7);
        chk("t2_max", 32'(bus0.irq_max), 32'd2);
        th0 = 8'd2;
        step();
        chk("t2_kill_thresh", 32'(bus0.irq_kill_req), 32'd1);
        th0 = 8'd1;
        step();
        chk("t2_kill_drop", 32'(bus0.irq_kill_req), 32'd0);
        chk("t2_still_valid", 32'(bus0.irq_valid), 32'd1);
        bus0.irq_ready = 1'b1;
        step();
        chk("t2_claim", 32'(claim0), 32'h0080);
        bus0.irq_ready = 1'b0; ip0[7] = 1'b0; th0 = 8'd0;
        step();
        chk("t2_idle", 32'(st0), 32'd0);

        // T3: preemption, kill withdrawn when preemptor vanishes, then kill/ack and re-offer
        prio0[4] = 8'd2; mode0[4] = 2'd3; ip0[4] = 1'b1; ie0[4] = 1'b1;
        step();
        chk("t3_id4", 32'(bus0.irq_id), 32'd4);
        prio0[9] = 8'd6; mode0[9] = 2'd3; ip0[9] = 1'b1; ie0[9] = 1'b1;
        step();
        chk("t3_kill", 32'(bus0.irq_kill_req), 32'd1);
        chk("t3_valid_during_kill", 32'(bus0.irq_valid), 32'd1);
        ip0[9] = 1'b0;
        step();
        chk("t3_kill_withdrawn", 32'(bus0.irq_kill_req), 32'd0);
        chk("t3_id_held", 32'(bus0.irq_id), 32'd4);
        ip0[9] = 1'b1;
        step();
        chk("t3_kill_again", 32'(bus0.irq_kill_req), 32'd1);
        bus0.irq_kill_ack = 1'b1;
        step();
        chk("t3_ack_valid", 32'(bus0.irq_valid), 32'd0);
        chk("t3_ack_kill", 32'(bus0.irq_kill_req), 32'd0);
        chk("t3_ack_state", 32'(st0), 32'd0);
        chk("t3_ack_claim", 32'(claim0), 32'd0);
        bus0.irq_kill_ack = 1'b0;
        step();
        chk("t3_id9", 32'(bus0.irq_id), 32'd9);
        chk("t3_max9", 32'(bus0.irq_max), 32'd6);
        bus0.irq_ready = 1'b1;
        step();
        chk("t3_claim9", 32'(claim0), 32'h0200);
        bus0.irq_ready = 1'b0; ip0[9] = 1'b0; ip0[4] = 1'b0;
        step();

        // T4: full tie goes to the lower id; higher mode beats higher prio
        prio0[2] = 8'd5; mode0[2] = 2'd1; ip0[2] = 1'b1; ie0[2] = 1'b1;
        prio0[3] = 8'd5; mode0[3] = 2'd1; ip0[3] = 1'b1; ie0[3] = 1'b1;
        step();
        chk("t4_tie_id", 32'(bus0.irq_id), 32'd2);
        step();
        chk("t4_no_kill", 32'(bus0.irq_kill_req), 32'd0);
        bus0.irq_ready = 1'b1;
        step();
        chk("t4_claim2", 32'(claim0), 32'h0004);
        bus0.irq_ready = 1'b0;
        prio0[2] = 8'd7; prio0[3] = 8'd1; mode0[3] = 2'd3;
        step();
        step();
        chk("t4_mode_id", 32'(bus0.irq_id), 32'd3);
        chk("t4_mode_mode", 32'(bus0.irq_mode), 32'd3);
        chk("t4_mode_max", 32'(bus0.irq_max), 32'd1);
        bus0.irq_ready = 1'b1;
        step();
        chk("t4_claim3", 32'(claim0), 32'h0008);
        bus0.irq_ready = 1'b0; ip0[2] = 1'b0; ip0[3] = 1'b0;
        step();

        // T5: level-triggered source drops while offered
        prio0[6] = 8'd4; mode0[6] = 2'd2; le0[6] = 1'b0; ip0[6] = 1'b1; ie0[6] = 1'b1;
        step();
        chk("t5_id6", 32'(bus0.irq_id), 32'd6);
        ip0[6] = 1'b0;
        step();
        chk("t5_valid_drop", 32'(bus0.irq_valid), 32'd0);
        chk("t5_state_idle", 32'(st0), 32'd0);
        chk("t5_no_claim", 32'(claim0), 32'd0);
        step();
        chk("t5_no_claim_later", 32'(claim0), 32'd0);

        // T6: two-stage tree latency, flush length, asynchronous reset during an offer
        prio2[10] = 8'd4; mode2[10] = 2'd1; ip2[10] = 1'b1; ie2[10] = 1'b1;
        step();
        chk("t6_lat_c1", 32'(bus2.irq_valid), 32'd0);
        step();
        chk("t6_lat_c2", 32'(bus2.irq_valid), 32'd0);
        step();
        chk("t6_lat_c3", 32'(bus2.irq_valid), 32'd1);
        chk("t6_id10", 32'(bus2.irq_id), 32'd10);
        bus2.irq_ready = 1'b1;
        step();
        chk("t6_claim", 32'(claim2), 32'h0400);
        bus2.irq_ready = 1'b0; ip2[10] = 1'b0;
        step();
        chk("t6_flush1_state", 32'(st2), 32'd3);
        chk("t6_flush1_valid", 32'(bus2.irq_valid), 32'd0);
        chk("t6_flush1_claim", 32'(claim2), 32'd0);
        step();
        chk("t6_flush2_state", 32'(st2), 32'd3);
        chk("t6_flush2_valid", 32'(bus2.irq_valid), 32'd0);
        step();
        chk("t6_idle", 32'(st2), 32'd0);
        step();
        chk("t6_no_reoffer", 32'(bus2.irq_valid), 32'd0);

        prio2[11] = 8'd2; mode2[11] = 2'd0; ip2[11] = 1'b1; ie2[11] = 1'b1;
        repeat (3) step();
        chk("t6_offer11", 32'(bus2.irq_id), 32'd11);
        chk("t6_offer11_valid", 32'(bus2.irq_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(bus2.irq_valid), 32'd0);
        chk("t6_rst_kill", 32'(bus2.irq_kill_req), 32'd0);
        chk("t6_rst_claim", 32'(claim2), 32'd0);
        chk("t6_rst_state", 32'(st2), 32'd0);
        chk("t6_rst_id", 32'(bus2.irq_id), 32'd0);
        ip2[11] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) step();
        chk("t6_post_rst_idle", 32'(st2), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
